// File: rtl/rx_serial_7o1_if.sv
// Receiver-side signal bundle for the 7O1 serial receiver.
// The master drives the RX line and limpa. The slave (the receiver) drives the character outputs.
interface rx_serial_7o1_if;
  logic       entrada_serial;
  logic       limpa;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro_paridade;
  logic       erro_stop;
  logic [3:0] db_estado;

  modport master (
    output entrada_serial,
    output limpa,
    input  dados_ascii,
    input  pronto,
    input  tem_dado,
    input  erro_paridade,
    input  erro_stop,
    input  db_estado
  );

  modport slave (
    input  entrada_serial,
    input  limpa,
    output dados_ascii,
    output pronto,
    output tem_dado,
    output erro_paridade,
    output erro_stop,
    output db_estado
  );
endinterface

// File: rtl/rx_serial_7o1.sv
// UART receiver for 7O1 frames (start, 7 data bits LSB first, odd parity, stop).
// Delivers each character with a pronto pulse, a held tem_dado flag and parity/framing flags.
module rx_serial_7o1 #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned HALF_BIT     = 217
) (
  input  logic            clock,
  input  logic            reset,
  rx_serial_7o1_if.slave  bus
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TimerOne  = TW'(1);
  localparam logic [TW-1:0] TimerLast = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TimerHalf = TW'(HALF_BIT - 1);

  typedef enum logic [3:0] {
    StEsperaRepouso = 4'd0,
    StInicial       = 4'd1,
    StStart         = 4'd2,
    StDados         = 4'd3,
    StParidade      = 4'd4,
    StStop          = 4'd5,
    StFim           = 4'd6,
    StErro          = 4'd7
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [6:0]    dados_q, dados_d;
  logic          tem_dado_q, tem_dado_d;
  logic          erro_par_q, erro_par_d;
  logic          erro_stop_q, erro_stop_d;
  logic          rx_meta_q, rx_s_q;
  logic          bit_end;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.entrada_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign bit_end = (timer_q == TimerLast);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    dados_d     = dados_q;
    tem_dado_d  = tem_dado_q;
    erro_par_d  = erro_par_q;
    erro_stop_d = erro_stop_q;

    if (bus.limpa) begin
      tem_dado_d = 1'b0;
    end

    case (state_q)
      StEsperaRepouso: begin
        if (rx_s_q) state_d = StInicial;
      end
      StInicial: begin
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (timer_q == TimerHalf) begin
          bit_cnt_d = 3'd0;
          state_d   = rx_s_q ? StInicial : StDados;
        end
      end
      StDados: begin
        if (bit_end) begin
          shift_d   = {rx_s_q, shift_q[6:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd6) state_d = StParidade;
        end
      end
      StParidade: begin
        if (bit_end) begin
          parity_d = rx_s_q;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (bit_end) state_d = rx_s_q ? StFim : StErro;
      end
      StFim: begin
        // Setting tem_dado here overrides a simultaneous limpa.
        dados_d     = shift_q;
        tem_dado_d  = 1'b1;
        erro_par_d  = ~(^{shift_q, parity_q});
        erro_stop_d = 1'b0;
        state_d     = StInicial;
      end
      StErro: begin
        erro_stop_d = 1'b1;
        state_d     = StEsperaRepouso;
      end
      default: begin
        state_d = StEsperaRepouso;
      end
    endcase

    timer_d = ((state_d != state_q) || bit_end) ? '0 : timer_q + TimerOne;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StEsperaRepouso;
      timer_q     <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      parity_q    <= 1'b0;
      dados_q     <= 7'd0;
      tem_dado_q  <= 1'b0;
      erro_par_q  <= 1'b0;
      erro_stop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      dados_q     <= dados_d;
      tem_dado_q  <= tem_dado_d;
      erro_par_q  <= erro_par_d;
      erro_stop_q <= erro_stop_d;
    end
  end

  assign bus.dados_ascii   = dados_q;
  assign bus.pronto        = (state_q == StFim);
  assign bus.tem_dado      = tem_dado_q;
  assign bus.erro_paridade = erro_par_q;
  assign bus.erro_stop     = erro_stop_q;
  assign bus.db_estado     = state_q;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Directed bench for rx_serial_7o1: table of well-formed frames plus hand-written corner cases
// (glitch, framing error with held-low line, reset mid-frame, back-to-back with limpa).
module tb_rx_serial_7o1;

  localparam int unsigned CPB  = 434;
  localparam int unsigned HALF = 217;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rx_serial_7o1_if bus ();

  rx_serial_7o1 #(
    .CLKS_PER_BIT(CPB),
    .HALF_BIT    (HALF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int   n_checks     = 0;
  int   n_fail       = 0;
  int   pronto_total = 0;
  logic pronto_prev  = 1'b0;
  logic consec_err   = 1'b0;

  always @(negedge clock) begin
    if (bus.pronto) pronto_total <= pronto_total + 1;
    if (bus.pronto && pronto_prev) consec_err <= 1'b1;
    pronto_prev <= bus.pronto;
  end

  typedef struct {
    logic [6:0] data;
    logic       par;
    logic [6:0] exp_dados;
    logic       exp_par_err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hold the line at lvl for n cycles; optionally mirror pronto onto limpa each cycle.
  task automatic hold(input logic lvl, input int unsigned n, input bit clr_on_pronto);
    bus.entrada_serial = lvl;
    repeat (n) begin
      @(negedge clock);
      if (clr_on_pronto) bus.limpa = bus.pronto;
    end
  endtask

  task automatic send_frame(input logic [6:0] d, input logic par, input logic stop,
                            input logic idle, input bit clr_on_pronto);
    hold(1'b0, CPB, 1'b0);
    for (int i = 0; i < 7; i++) hold(d[i], CPB, 1'b0);
    hold(par, CPB, 1'b0);
    hold(stop, CPB, clr_on_pronto);
    bus.entrada_serial = idle;
    bus.limpa          = 1'b0;
  endtask

  initial begin
    int p0;
    vecs[0] = '{data: 7'h41, par: 1'b1, exp_dados: 7'h41, exp_par_err: 1'b0};
    vecs[1] = '{data: 7'h35, par: 1'b0, exp_dados: 7'h35, exp_par_err: 1'b1};
    vecs[2] = '{data: 7'h00, par: 1'b0, exp_dados: 7'h00, exp_par_err: 1'b1};
    vecs[3] = '{data: 7'h7f, par: 1'b0, exp_dados: 7'h7f, exp_par_err: 1'b0};

    bus.entrada_serial = 1'b1;
    bus.limpa          = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_dados", 32'(bus.dados_ascii), 32'h0);
    check("rst_pronto", 32'(bus.pronto), 32'h0);
    check("rst_tem_dado", 32'(bus.tem_dado), 32'h0);
    check("rst_erro_par", 32'(bus.erro_paridade), 32'h0);
    check("rst_erro_stop", 32'(bus.erro_stop), 32'h0);
    check("rst_estado", 32'(bus.db_estado), 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_estado", 32'(bus.db_estado), 32'h1);

    // Well-formed frames from the table, each followed by a limpa pulse.
    for (int v = 0; v < 4; v++) begin
      p0 = pronto_total;
      send_frame(vecs[v].data, vecs[v].par, 1'b1, 1'b1, 1'b0);
      repeat (10) @(negedge clock);
      check("vec_pronto_cnt", 32'(pronto_total - p0), 32'd1);
      check("vec_dados", 32'(bus.dados_ascii), 32'(vecs[v].exp_dados));
      check("vec_tem_dado", 32'(bus.tem_dado), 32'h1);
      check("vec_erro_par", 32'(bus.erro_paridade), 32'(vecs[v].exp_par_err));
      check("vec_erro_stop", 32'(bus.erro_stop), 32'h0);
      bus.limpa = 1'b1;
      @(negedge clock);
      bus.limpa = 1'b0;
      @(negedge clock);
      check("vec_limpa", 32'(bus.tem_dado), 32'h0);
    end

    // Short low glitch: rejected at the start-bit mid sample.
    p0 = pronto_total;
    hold(1'b0, 100, 1'b0);
    check("glitch_in_start", 32'(bus.db_estado), 32'h2);
    hold(1'b1, 400, 1'b0);
    check("glitch_estado", 32'(bus.db_estado), 32'h1);
    check("glitch_pronto", 32'(pronto_total - p0), 32'd0);
    check("glitch_dados", 32'(bus.dados_ascii), 32'h7f);

    // Framing error, line held low, then recovery with '#'.
    p0 = pronto_total;
    send_frame(7'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    check("ferr_erro_stop", 32'(bus.erro_stop), 32'h1);
    check("ferr_pronto", 32'(pronto_total - p0), 32'd0);
    check("ferr_dados", 32'(bus.dados_ascii), 32'h7f);
    check("ferr_estado", 32'(bus.db_estado), 32'h0);
    hold(1'b0, 2000, 1'b0);
    check("ferr_low_pronto", 32'(pronto_total - p0), 32'd0);
    check("ferr_low_estado", 32'(bus.db_estado), 32'h0);
    hold(1'b1, 20, 1'b0);
    check("ferr_recover_estado", 32'(bus.db_estado), 32'h1);
    send_frame(7'h23, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clock);
    check("ferr_next_dados", 32'(bus.dados_ascii), 32'h23);
    check("ferr_next_erro_stop", 32'(bus.erro_stop), 32'h0);
    check("ferr_next_erro_par", 32'(bus.erro_paridade), 32'h0);
    check("ferr_next_pronto", 32'(pronto_total - p0), 32'd1);

    // Reset during data bit 3 of 'A' (bits 1,0,0,0...).
    hold(1'b0, CPB, 1'b0);
    hold(1'b1, CPB, 1'b0);
    hold(1'b0, CPB, 1'b0);
    hold(1'b0, CPB, 1'b0);
    hold(1'b0, CPB / 2, 1'b0);
    reset              = 1'b0;
    bus.entrada_serial = 1'b1;
    repeat (3) @(negedge clock);
    check("mrst_dados", 32'(bus.dados_ascii), 32'h0);
    check("mrst_tem_dado", 32'(bus.tem_dado), 32'h0);
    check("mrst_pronto", 32'(bus.pronto), 32'h0);
    check("mrst_estado", 32'(bus.db_estado), 32'h0);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("mrst_idle_estado", 32'(bus.db_estado), 32'h1);
    check("mrst_idle_dados", 32'(bus.dados_ascii), 32'h0);
    p0 = pronto_total;
    send_frame(7'h41, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clock);
    check("mrst_next_dados", 32'(bus.dados_ascii), 32'h41);
    check("mrst_next_tem_dado", 32'(bus.tem_dado), 32'h1);
    check("mrst_next_pronto", 32'(pronto_total - p0), 32'd1);

    // Back-to-back '#' then 'A', limpa asserted in the cycle of the second pronto.
    bus.limpa = 1'b1;
    @(negedge clock);
    bus.limpa = 1'b0;
    repeat (5) @(negedge clock);
    p0 = pronto_total;
    send_frame(7'h23, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(7'h41, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (10) @(negedge clock);
    check("b2b_pronto_cnt", 32'(pronto_total - p0), 32'd2);
    check("b2b_dados", 32'(bus.dados_ascii), 32'h41);
    check("b2b_tem_dado", 32'(bus.tem_dado), 32'h1);
    check("b2b_erro_par", 32'(bus.erro_paridade), 32'h0);

    check("pronto_not_consecutive", 32'(consec_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
